// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- FSM controller for a multicycle processor datapath.
//
// Sequences each instruction through IF, ID, EXE, (MEM), (WB) and drives the
// datapath strobes. It halts on an illegal instruction, or when memory fails
// to answer within TIMEOUT cycles. It also counts retired instructions.
//
// Instruction encoding:
//   opcode = instr[INSTR_WIDTH-1 -: OPCODE_WIDTH]
//   func   = instr[FUNC_WIDTH-1:0]
// Opcodes: RTYPE=0 ADDI=1 SUBI=2 ANDI=3 ORI=4 XORI=5 LW=6 SW=7 BEQ=8 BNE=9
//          LUI=10 LLI=11 JR=12 JMP=13 JAL=14
// RTYPE funcs: ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLL=5 SRL=6 SLA=7 SRA=8 JR=9
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   instr            memory read data, loaded into IR in IF when mem_ready=1
//   mem_ready        memory access completes this cycle
//   alu_zero         ALU zero flag, used by branches in EXE
//   state            current state (IF=0 ID=1 EXE=2 MEM=3 WB=4 HALT=5)
//   mem_req, mem_we  memory request / write enable
//   ir_we, pc_we     instruction register / program counter write enables
//   reg_we           register file write enable
//   pc_src           0=PC+4, 1=branch target, 2=absolute jump, 3=register
//   alu_op           ALU operation select
//   alu_src_imm      ALU operand B comes from the immediate
//   link             JAL link-register write
//   illegal, timeout sticky HALT cause flags
//   retired          count of completed instructions (wraps)
module multicycle_ctrl #(
  parameter int INSTR_WIDTH  = 32,
  parameter int OPCODE_WIDTH = 6,
  parameter int FUNC_WIDTH   = 6,
  parameter int TIMEOUT      = 16,
  parameter int RETIRE_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [INSTR_WIDTH-1:0]  instr,
  input  logic                    mem_ready,
  input  logic                    alu_zero,
  output logic [2:0]              state,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic                    ir_we,
  output logic                    pc_we,
  output logic                    reg_we,
  output logic [1:0]              pc_src,
  output logic [3:0]              alu_op,
  output logic                    alu_src_imm,
  output logic                    link,
  output logic                    illegal,
  output logic                    timeout,
  output logic [RETIRE_WIDTH-1:0] retired
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUBI  = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_ANDI  = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_ORI   = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_XORI  = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_LW    = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_SW    = OPCODE_WIDTH'(7);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = OPCODE_WIDTH'(8);
  localparam logic [OPCODE_WIDTH-1:0] OP_BNE   = OPCODE_WIDTH'(9);
  localparam logic [OPCODE_WIDTH-1:0] OP_LUI   = OPCODE_WIDTH'(10);
  localparam logic [OPCODE_WIDTH-1:0] OP_LLI   = OPCODE_WIDTH'(11);
  localparam logic [OPCODE_WIDTH-1:0] OP_JR    = OPCODE_WIDTH'(12);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP   = OPCODE_WIDTH'(13);
  localparam logic [OPCODE_WIDTH-1:0] OP_JAL   = OPCODE_WIDTH'(14);

  localparam logic [FUNC_WIDTH-1:0] F_ADD = FUNC_WIDTH'(0);
  localparam logic [FUNC_WIDTH-1:0] F_SUB = FUNC_WIDTH'(1);
  localparam logic [FUNC_WIDTH-1:0] F_AND = FUNC_WIDTH'(2);
  localparam logic [FUNC_WIDTH-1:0] F_OR  = FUNC_WIDTH'(3);
  localparam logic [FUNC_WIDTH-1:0] F_XOR = FUNC_WIDTH'(4);
  localparam logic [FUNC_WIDTH-1:0] F_SLL = FUNC_WIDTH'(5);
  localparam logic [FUNC_WIDTH-1:0] F_SRL = FUNC_WIDTH'(6);
  localparam logic [FUNC_WIDTH-1:0] F_SLA = FUNC_WIDTH'(7);
  localparam logic [FUNC_WIDTH-1:0] F_SRA = FUNC_WIDTH'(8);
  localparam logic [FUNC_WIDTH-1:0] F_JR  = FUNC_WIDTH'(9);

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_SLA = 4'd7;
  localparam logic [3:0] ALU_SRA = 4'd8;
  localparam logic [3:0] ALU_LUI = 4'd9;
  localparam logic [3:0] ALU_LLI = 4'd10;

  // Sized so the counter can hold TIMEOUT-1 for any TIMEOUT >= 1
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t                  state_q, state_d, cur;
  logic [INSTR_WIDTH-1:0]  ir;
  logic [WAIT_W-1:0]       wait_cnt, wait_d;
  logic                    set_illegal, set_timeout, retire_inc;

  logic [OPCODE_WIDTH-1:0] opcode;
  logic [FUNC_WIDTH-1:0]   func;
  logic                    legal, dec_imm;
  logic                    is_wb, is_lw, is_sw, is_beq, is_bne;
  logic                    is_jmp, is_jal, is_jr;
  logic [3:0]              dec_alu_op;
  logic                    ir_unused;

  assign opcode = ir[INSTR_WIDTH-1 -: OPCODE_WIDTH];
  assign func   = ir[FUNC_WIDTH-1:0];
  // The operand fields between opcode and func belong to the datapath
  assign ir_unused = ^ir;
  assign state  = state_q;

  // While reset is asserted the strobes already look like IF, whatever
  // state the register still holds.
  assign cur = rst ? S_IF : state_q;

  // Instruction decoder working from the latched IR
  always_comb begin
    legal      = 1'b0;
    dec_imm    = 1'b0;
    is_wb      = 1'b0;
    is_lw      = 1'b0;
    is_sw      = 1'b0;
    is_beq     = 1'b0;
    is_bne     = 1'b0;
    is_jmp     = 1'b0;
    is_jal     = 1'b0;
    is_jr      = 1'b0;
    dec_alu_op = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        case (func)
          F_ADD: begin legal = 1'b1; is_wb = 1'b1; dec_alu_op = ALU_ADD; end
          F_SUB: begin legal = 1'b1; is_wb = 1'b1; dec_alu_op = ALU_SUB; end
          F_AND: begin legal = 1'b1; is_wb = 1'b1; dec_alu_op = ALU_AND; end
          F_OR:  begin legal = 1'b1; is_wb = 1'b1; dec_alu_op = ALU_OR;  end
          F_XOR: begin legal = 1'b1; is_wb = 1'b1; dec_alu_op = ALU_XOR; end
          F_SLL: begin legal = 1'b1; is_wb = 1'b1; dec_alu_op = ALU_SLL; end
          F_SRL: begin legal = 1'b1; is_wb = 1'b1; dec_alu_op = ALU_SRL; end
          F_SLA: begin legal = 1'b1; is_wb = 1'b1; dec_alu_op = ALU_SLA; end
          F_SRA: begin legal = 1'b1; is_wb = 1'b1; dec_alu_op = ALU_SRA; end
          F_JR:  begin legal = 1'b1; is_jr = 1'b1; end
          default: ;
        endcase
      end
      OP_ADDI: begin legal = 1'b1; is_wb = 1'b1; dec_imm = 1'b1; dec_alu_op = ALU_ADD; end
      OP_SUBI: begin legal = 1'b1; is_wb = 1'b1; dec_imm = 1'b1; dec_alu_op = ALU_SUB; end
      OP_ANDI: begin legal = 1'b1; is_wb = 1'b1; dec_imm = 1'b1; dec_alu_op = ALU_AND; end
      OP_ORI:  begin legal = 1'b1; is_wb = 1'b1; dec_imm = 1'b1; dec_alu_op = ALU_OR;  end
      OP_XORI: begin legal = 1'b1; is_wb = 1'b1; dec_imm = 1'b1; dec_alu_op = ALU_XOR; end
      OP_LUI:  begin legal = 1'b1; is_wb = 1'b1; dec_imm = 1'b1; dec_alu_op = ALU_LUI; end
      OP_LLI:  begin legal = 1'b1; is_wb = 1'b1; dec_imm = 1'b1; dec_alu_op = ALU_LLI; end
      OP_LW:   begin legal = 1'b1; is_lw = 1'b1; dec_imm = 1'b1; dec_alu_op = ALU_ADD; end
      OP_SW:   begin legal = 1'b1; is_sw = 1'b1; dec_imm = 1'b1; dec_alu_op = ALU_ADD; end
      OP_BEQ:  begin legal = 1'b1; is_beq = 1'b1; dec_alu_op = ALU_SUB; end
      OP_BNE:  begin legal = 1'b1; is_bne = 1'b1; dec_alu_op = ALU_SUB; end
      OP_JR:   begin legal = 1'b1; is_jr = 1'b1; end
      OP_JMP:  begin legal = 1'b1; is_jmp = 1'b1; end
      OP_JAL:  begin legal = 1'b1; is_jal = 1'b1; end
      default: ;
    endcase
  end

  // Next-state and strobe logic. The wait counter advances only while IF or
  // MEM is stalled on memory; every other path leaves it cleared.
  always_comb begin
    state_d     = state_q;
    wait_d      = '0;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    retire_inc  = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    reg_we      = 1'b0;
    pc_src      = 2'd0;
    alu_op      = ALU_ADD;
    alu_src_imm = 1'b0;
    link        = 1'b0;
    case (cur)
      S_IF: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_ID;
        end else if (wait_cnt == WAIT_LAST) begin
          state_d     = S_HALT;
          set_timeout = 1'b1;
        end else begin
          wait_d = wait_cnt + WAIT_W'(1);
        end
      end
      S_ID: begin
        if (legal) begin
          state_d = S_EXE;
        end else begin
          state_d     = S_HALT;
          set_illegal = 1'b1;
        end
      end
      S_EXE: begin
        alu_op      = dec_alu_op;
        alu_src_imm = dec_imm;
        if (is_beq || is_bne) begin
          pc_we      = is_beq ? alu_zero : !alu_zero;
          pc_src     = 2'd1;
          state_d    = S_IF;
          retire_inc = 1'b1;
        end else if (is_jmp || is_jal) begin
          pc_we  = 1'b1;
          pc_src = 2'd2;
          if (is_jal) begin
            state_d = S_WB;
          end else begin
            state_d    = S_IF;
            retire_inc = 1'b1;
          end
        end else if (is_jr) begin
          pc_we      = 1'b1;
          pc_src     = 2'd3;
          state_d    = S_IF;
          retire_inc = 1'b1;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else if (is_wb) begin
          state_d = S_WB;
        end else begin
          state_d     = S_HALT;
          set_illegal = 1'b1;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = is_sw;
        if (mem_ready) begin
          if (is_sw) begin
            state_d    = S_IF;
            retire_inc = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          state_d     = S_HALT;
          set_timeout = 1'b1;
        end else begin
          wait_d = wait_cnt + WAIT_W'(1);
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        link       = is_jal;
        state_d    = S_IF;
        retire_inc = 1'b1;
      end
      S_HALT: ;
      default: state_d = S_IF;
    endcase
  end

  // State, IR, wait counter, sticky flags and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IF;
      ir       <= '0;
      wait_cnt <= '0;
      illegal  <= 1'b0;
      timeout  <= 1'b0;
      retired  <= '0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= wait_d;
      if (ir_we)       ir      <= instr;
      if (set_illegal) illegal <= 1'b1;
      if (set_timeout) timeout <= 1'b1;
      if (retire_inc)  retired <= retired + RETIRE_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl -- scoreboard bench for multicycle_ctrl.
//
// The stimulus process drives one cycle at a time and queues the expected
// outputs for that cycle, tagged with the cycle number. The monitor pops
// every due expectation on the falling edge and compares it.
module tb_multicycle_ctrl;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_ORI   = 6'd4;
  localparam logic [5:0] OP_LW    = 6'd6;
  localparam logic [5:0] OP_SW    = 6'd7;
  localparam logic [5:0] OP_BEQ   = 6'd8;
  localparam logic [5:0] OP_BNE   = 6'd9;
  localparam logic [5:0] OP_LUI   = 6'd10;
  localparam logic [5:0] OP_JMP   = 6'd13;
  localparam logic [5:0] OP_JAL   = 6'd14;
  localparam logic [5:0] OP_BAD   = 6'h3F;
  localparam logic [5:0] F_ADD    = 6'd0;
  localparam logic [5:0] F_SRA    = 6'd8;
  localparam logic [5:0] F_JR     = 6'd9;

  localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EXE = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5;

  localparam int SEL_STATE = 0, SEL_STROBES = 1, SEL_FLAGS = 2, SEL_RET = 3;
  localparam logic [31:0] JUNK = 32'hFFFF_FFFF;

  typedef struct {
    string       name;
    int          cyc;
    int          sel;
    logic [15:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        mem_ready, alu_zero;
  logic [2:0]  state;
  logic        mem_req, mem_we, ir_we, pc_we, reg_we;
  logic [1:0]  pc_src;
  logic [3:0]  alu_op;
  logic        alu_src_imm, link, illegal, timeout;
  logic [3:0]  retired;

  exp_t scb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  multicycle_ctrl #(.RETIRE_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
    .alu_zero(alu_zero), .state(state), .mem_req(mem_req), .mem_we(mem_we),
    .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we), .pc_src(pc_src),
    .alu_op(alu_op), .alu_src_imm(alu_src_imm), .link(link),
    .illegal(illegal), .timeout(timeout), .retired(retired)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [5:0] fn);
    return {op, 20'h5A5A5, fn};
  endfunction

  // Packs {mem_req,mem_we,ir_we,pc_we,reg_we,pc_src,alu_op,alu_src_imm,link}
  function automatic logic [12:0] sb(input logic mreq, mwe, irwe, pcwe, regwe,
                                     input logic [1:0] pcs, input logic [3:0] aop,
                                     input logic imm, lnk);
    return {mreq, mwe, irwe, pcwe, regwe, pcs, aop, imm, lnk};
  endfunction

  task automatic checkOutput(input exp_t e);
    logic [15:0] act;
    case (e.sel)
      SEL_STATE:   act = {13'd0, state};
      SEL_STROBES: act = {3'd0, mem_req, mem_we, ir_we, pc_we, reg_we, pc_src,
                          alu_op, alu_src_imm, link};
      SEL_FLAGS:   act = {14'd0, illegal, timeout};
      default:     act = {12'd0, retired};
    endcase
    n_checks++;
    if (act === e.val && e.cyc == cyc) n_pass++;
    else $display("[TB] FAIL %s sel=%0d cycle=%0d (due %0d): got 0x%0h expected 0x%0h",
                  e.name, e.sel, cyc, e.cyc, act, e.val);
  endtask

  // Monitor: compare every expectation that has fallen due this cycle
  always @(negedge clk) begin
    while (scb.size() > 0 && scb[0].cyc <= cyc) checkOutput(scb.pop_front());
  end

  task automatic expectAt(input string nm, input int sel, input logic [15:0] v);
    exp_t e;
    e.name = nm; e.cyc = cyc; e.sel = sel; e.val = v;
    scb.push_back(e);
  endtask

  task automatic stepRaw(input logic [31:0] i, input logic mr, input logic az);
    instr = i; mem_ready = mr; alu_zero = az;
    @(posedge clk); #1;
  endtask

  task automatic applyStimulus(input logic [31:0] i, input logic mr, input logic az,
                               input logic [2:0] es, input logic [12:0] estr,
                               input string nm);
    expectAt({nm, " state"}, SEL_STATE, {13'd0, es});
    expectAt({nm, " strobes"}, SEL_STROBES, {3'd0, estr});
    stepRaw(i, mr, az);
  endtask

  task automatic fetchDecode(input logic [31:0] i, input string nm);
    applyStimulus(i, 1'b1, 1'b0, S_IF, sb(1,0,1,1,0,2'd0,4'd0,0,0), {nm, " if"});
    applyStimulus(JUNK, 1'b1, 1'b0, S_ID, 13'd0, {nm, " id"});
  endtask

  initial begin
    logic [12:0] if_wait, wb_only;
    if_wait = sb(1,0,0,0,0,2'd0,4'd0,0,0);
    wb_only = sb(0,0,0,0,1,2'd0,4'd0,0,0);
    rst = 1'b1; instr = '0; mem_ready = 1'b0; alu_zero = 1'b0;
    @(posedge clk); #1;

    expectAt("reset flags", SEL_FLAGS, 16'd0);
    expectAt("reset retired", SEL_RET, 16'd0);
    applyStimulus(JUNK, 0, 0, S_IF, if_wait, "in reset");
    rst = 1'b0;
    applyStimulus(JUNK, 0, 0, S_IF, if_wait, "post reset");

    // ADD: IF, ID, EXE, WB
    fetchDecode(mk(OP_RTYPE, F_ADD), "add");
    applyStimulus(JUNK, 1, 0, S_EXE, 13'd0, "add exe");
    applyStimulus(JUNK, 1, 0, S_WB, wb_only, "add wb");

    // BEQ taken, then BNE not taken, both with alu_zero=1
    expectAt("retired after add", SEL_RET, 16'd1);
    fetchDecode(mk(OP_BEQ, 6'd0), "beq");
    applyStimulus(JUNK, 1, 1, S_EXE, sb(0,0,0,1,0,2'd1,4'd1,0,0), "beq exe");
    expectAt("retired after beq", SEL_RET, 16'd2);
    fetchDecode(mk(OP_BNE, 6'd0), "bne");
    applyStimulus(JUNK, 1, 1, S_EXE, sb(0,0,0,0,0,2'd1,4'd1,0,0), "bne exe");

    // LW with memory stalled three cycles in MEM
    expectAt("retired after bne", SEL_RET, 16'd3);
    fetchDecode(mk(OP_LW, 6'd0), "lw");
    applyStimulus(JUNK, 1, 0, S_EXE, sb(0,0,0,0,0,2'd0,4'd0,1,0), "lw exe");
    for (int k = 0; k < 3; k++)
      applyStimulus(JUNK, 0, 0, S_MEM, if_wait, "lw mem stall");
    applyStimulus(JUNK, 1, 0, S_MEM, if_wait, "lw mem done");
    applyStimulus(JUNK, 1, 0, S_WB, wb_only, "lw wb");

    expectAt("retired after lw", SEL_RET, 16'd4);
    fetchDecode(mk(OP_SW, 6'd0), "sw");
    applyStimulus(JUNK, 1, 0, S_EXE, sb(0,0,0,0,0,2'd0,4'd0,1,0), "sw exe");
    applyStimulus(JUNK, 1, 0, S_MEM, sb(1,1,0,0,0,2'd0,4'd0,0,0), "sw mem");

    expectAt("retired after sw", SEL_RET, 16'd5);
    fetchDecode(mk(OP_JAL, 6'd0), "jal");
    applyStimulus(JUNK, 1, 0, S_EXE, sb(0,0,0,1,0,2'd2,4'd0,0,0), "jal exe");
    applyStimulus(JUNK, 1, 0, S_WB, sb(0,0,0,0,1,2'd0,4'd0,0,1), "jal wb");

    expectAt("retired after jal", SEL_RET, 16'd6);
    fetchDecode(mk(OP_RTYPE, F_JR), "jr");
    applyStimulus(JUNK, 1, 0, S_EXE, sb(0,0,0,1,0,2'd3,4'd0,0,0), "jr exe");

    expectAt("retired after jr", SEL_RET, 16'd7);
    fetchDecode(mk(OP_ORI, 6'd0), "ori");
    applyStimulus(JUNK, 1, 0, S_EXE, sb(0,0,0,0,0,2'd0,4'd3,1,0), "ori exe");
    applyStimulus(JUNK, 1, 0, S_WB, wb_only, "ori wb");

    fetchDecode(mk(OP_RTYPE, F_SRA), "sra");
    applyStimulus(JUNK, 1, 0, S_EXE, sb(0,0,0,0,0,2'd0,4'd8,0,0), "sra exe");
    applyStimulus(JUNK, 1, 0, S_WB, wb_only, "sra wb");

    fetchDecode(mk(OP_LUI, 6'd0), "lui");
    applyStimulus(JUNK, 1, 0, S_EXE, sb(0,0,0,0,0,2'd0,4'd9,1,0), "lui exe");
    applyStimulus(JUNK, 1, 0, S_WB, wb_only, "lui wb");

    // Short IF stall, then an illegal opcode
    expectAt("retired after lui", SEL_RET, 16'd10);
    applyStimulus(JUNK, 0, 0, S_IF, if_wait, "if stall");
    applyStimulus(JUNK, 0, 0, S_IF, if_wait, "if stall");
    fetchDecode(mk(OP_BAD, 6'd0), "illegal");
    for (int k = 0; k < 20; k++) begin
      if (k == 0 || k == 19) begin
        expectAt("halt illegal flags", SEL_FLAGS, 16'b10);
        expectAt("halt retired held", SEL_RET, 16'd10);
      end
      applyStimulus(JUNK, 1, 1, S_HALT, 13'd0, "halt illegal");
    end

    // Reset out of HALT
    rst = 1'b1;
    expectAt("reset in halt strobes", SEL_STROBES, {3'd0, if_wait});
    stepRaw(JUNK, 0, 0);
    rst = 1'b0;
    expectAt("flags after halt reset", SEL_FLAGS, 16'd0);
    expectAt("retired after halt reset", SEL_RET, 16'd0);
    applyStimulus(JUNK, 0, 0, S_IF, if_wait, "after halt reset");

    // 16 JMPs with a 4-bit retire counter: 15 wraps to 0
    for (int k = 1; k <= 16; k++) begin
      fetchDecode(mk(OP_JMP, 6'd0), "jmp");
      applyStimulus(JUNK, 1, 0, S_EXE, sb(0,0,0,1,0,2'd2,4'd0,0,0), "jmp exe");
      expectAt("jmp retired", SEL_RET, 16'(k % 16));
    end

    // IF timeout: 16 stalled cycles, then HALT with timeout set
    for (int k = 0; k < 16; k++)
      applyStimulus(JUNK, 0, 0, S_IF, if_wait, "timeout wait");
    expectAt("timeout flags", SEL_FLAGS, 16'b01);
    applyStimulus(JUNK, 1, 0, S_HALT, 13'd0, "timeout halt");
    applyStimulus(JUNK, 1, 0, S_HALT, 13'd0, "timeout halt");

    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (scb.size() == 0) n_pass++;
    else $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", scb.size());
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
